// File: rtl/egress_drain_pkg.sv
// Shared widths, state encoding and word layout for the egress drain block.
package egress_drain_pkg;

   localparam int unsigned WORD_W    = 10;
   localparam int unsigned CLASS_W   = 2;
   localparam int unsigned PAYLOAD_W = WORD_W - CLASS_W;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned NUM_FIFO  = 4;
   localparam int unsigned IDX_W     = $clog2(NUM_FIFO);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   typedef struct packed {
      logic [CLASS_W-1:0]   cls;
      logic [PAYLOAD_W-1:0] payload;
   } word_t;

endpackage

// File: rtl/egress_drain_rr_arbiter4.sv
// Four-way round-robin pop arbiter with registered one-hot grant.
// The source granted last cycle is masked because its empty flag is still stale.
module rr_arbiter4
   import egress_drain_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                en_i,
   input  logic [NUM_FIFO-1:0] req_i,
   output logic [NUM_FIFO-1:0] gnt_o,
   output logic [IDX_W-1:0]    gnt_idx_o
);

   logic [NUM_FIFO-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [NUM_FIFO-1:0] elig_c;
   logic [IDX_W-1:0]    cand_c;
   logic                found_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q <= '0;
         idx_q <= '0;
         ptr_q <= IDX_W'(NUM_FIFO - 1);
      end else begin
         gnt_q <= gnt_d;
         idx_q <= idx_d;
         ptr_q <= ptr_d;
      end
   end

   // Search starts one past the last granted source.
   always_comb begin
      gnt_d   = '0;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      found_c = 1'b0;
      cand_c  = '0;
      elig_c  = req_i & ~gnt_q;
      if (en_i) begin
         for (int unsigned k = 1; k <= NUM_FIFO; k++) begin
            cand_c = IDX_W'(32'(ptr_q) + k);
            if (!found_c && elig_c[cand_c]) begin
               found_c       = 1'b1;
               gnt_d[cand_c] = 1'b1;
               idx_d         = cand_c;
               ptr_d         = cand_c;
            end
         end
      end
   end

   assign gnt_o     = gnt_q;
   assign gnt_idx_o = idx_q;

endmodule

// File: rtl/egress_drain.sv
// Drains four output FIFOs round-robin to a single downstream port and keeps
// per-source delivery counters readable through a request port.
module egress_drain
   import egress_drain_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [WORD_W-1:0] fifo4_out,
   input  logic [WORD_W-1:0] fifo5_out,
   input  logic [WORD_W-1:0] fifo6_out,
   input  logic [WORD_W-1:0] fifo7_out,
   input  logic              empty4,
   input  logic              empty5,
   input  logic              empty6,
   input  logic              empty7,
   input  logic              ready_in,
   input  logic              req,
   input  logic [IDX_W-1:0]  idx,
   output logic              pop4,
   output logic              pop5,
   output logic              pop6,
   output logic              pop7,
   output logic [WORD_W-1:0] data_out,
   output logic              valid_out,
   output logic [IDX_W-1:0]  src_out,
   output logic [CNT_W-1:0]  data_cnt,
   output logic              valid_cnt,
   output logic              idle
);

   state_e              state_q, state_d;
   logic                inflight_q, inflight_d;
   logic [IDX_W-1:0]    src_q, src_d;
   logic [CNT_W-1:0]    cnt_q [NUM_FIFO];
   logic [CNT_W-1:0]    cnt_d [NUM_FIFO];
   logic [CNT_W-1:0]    data_cnt_q, data_cnt_d;
   logic                valid_cnt_q, valid_cnt_d;
   logic                idle_q, idle_d;

   logic [NUM_FIFO-1:0] empty_vec;
   logic [NUM_FIFO-1:0] pop_vec;
   logic [IDX_W-1:0]    gnt_idx;
   logic                arb_en_c;
   logic                all_empty_c;
   word_t               fifo_word [NUM_FIFO];

   assign empty_vec   = {empty7, empty6, empty5, empty4};
   assign all_empty_c = &empty_vec;
   assign arb_en_c    = (state_q == ST_ACTIVE) && ready_in && !init;

   rr_arbiter4 u_arb (
      .clk       (clk),
      .reset     (reset),
      .en_i      (arb_en_c),
      .req_i     (~empty_vec),
      .gnt_o     (pop_vec),
      .gnt_idx_o (gnt_idx)
   );

   assign {pop7, pop6, pop5, pop4} = pop_vec;

   // FIFO read data is registered at the source, so the delivered word is a
   // mux of it steered by the registered in-flight source.
   assign fifo_word[0] = word_t'(fifo4_out);
   assign fifo_word[1] = word_t'(fifo5_out);
   assign fifo_word[2] = word_t'(fifo6_out);
   assign fifo_word[3] = word_t'(fifo7_out);
   assign data_out     = inflight_q ? fifo_word[src_q] : '0;
   assign valid_out    = inflight_q;
   assign src_out      = src_q;
   assign data_cnt     = data_cnt_q;
   assign valid_cnt    = valid_cnt_q;
   assign idle         = idle_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_INIT;
         inflight_q  <= 1'b0;
         src_q       <= '0;
         data_cnt_q  <= '0;
         valid_cnt_q <= 1'b0;
         idle_q      <= 1'b0;
         for (int unsigned i = 0; i < NUM_FIFO; i++) cnt_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= inflight_d;
         src_q       <= src_d;
         data_cnt_q  <= data_cnt_d;
         valid_cnt_q <= valid_cnt_d;
         idle_q      <= idle_d;
         for (int unsigned i = 0; i < NUM_FIFO; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      inflight_d  = (|pop_vec) && !init;
      src_d       = (|pop_vec) ? gnt_idx : src_q;
      cnt_d       = cnt_q;
      valid_cnt_d = req;
      data_cnt_d  = req ? cnt_q[idx] : data_cnt_q;

      if (init) begin
         state_d = ST_INIT;
      end else begin
         unique case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (!all_empty_c) state_d = ST_ACTIVE;
            ST_ACTIVE: if (all_empty_c && !(|pop_vec) && !inflight_q) state_d = ST_IDLE;
            default:   state_d = ST_INIT;
         endcase
      end

      // Counters read before this cycle's increment, so a coinciding req sees the old value.
      if (init || state_q == ST_INIT) begin
         for (int unsigned i = 0; i < NUM_FIFO; i++) cnt_d[i] = '0;
      end else if (inflight_q) begin
         cnt_d[src_q] = cnt_q[src_q] + CNT_W'(1);
      end

      idle_d = (state_d == ST_IDLE);
   end

endmodule

// File: tb/tb_egress_drain.sv
// Bench for egress_drain: FIFO models, delivery scoreboard, counter model,
// a per-cycle pop vector table and hand-written corner-case sequences.
module tb_egress_drain;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init = 1'b1;
   logic [9:0] fo4 = '0, fo5 = '0, fo6 = '0, fo7 = '0;
   logic [3:0] emp = 4'hF;
   logic       ready_in = 1'b0;
   logic       req = 1'b0;
   logic [1:0] idx = '0;
   logic       pop4, pop5, pop6, pop7;
   logic [9:0] data_out;
   logic       valid_out;
   logic [1:0] src_out;
   logic [4:0] data_cnt;
   logic       valid_cnt;
   logic       idle;

   egress_drain dut (
      .clk(clk), .reset(reset), .init(init),
      .fifo4_out(fo4), .fifo5_out(fo5), .fifo6_out(fo6), .fifo7_out(fo7),
      .empty4(emp[0]), .empty5(emp[1]), .empty6(emp[2]), .empty7(emp[3]),
      .ready_in(ready_in), .req(req), .idx(idx),
      .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
      .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
      .data_cnt(data_cnt), .valid_cnt(valid_cnt), .idle(idle)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Output FIFO models: registered read data and registered empty flags.
   logic [9:0] q0[$], q1[$], q2[$], q3[$];
   int         seq = 0;

   always @(posedge clk) begin
      if (pop4 && q0.size() > 0) fo4 <= q0.pop_front();
      if (pop5 && q1.size() > 0) fo5 <= q1.pop_front();
      if (pop6 && q2.size() > 0) fo6 <= q2.pop_front();
      if (pop7 && q3.size() > 0) fo7 <= q3.pop_front();
      emp <= {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
   end

   task automatic push_words(input int f, input int n);
      logic [9:0] w;
      for (int i = 0; i < n; i++) begin
         w = {2'(f + seq), 8'(seq * 7 + 3)};
         seq++;
         case (f)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            default: q3.push_back(w);
         endcase
      end
   endtask

   // Scoreboard and counter model.
   typedef struct { logic [1:0] src; logic [9:0] data; } exp_t;
   exp_t sb[$];
   bit   mon_en = 1'b0;
   bit   pend = 1'b0;
   bit   rq_p = 1'b0;
   int   rq_exp = 0;
   int   cnt_m[4] = '{0, 0, 0, 0};
   logic ready_s = 1'b0;
   logic init_s = 1'b1;

   always @(posedge clk) begin
      ready_s <= ready_in;
      init_s  <= init;
   end

   always @(negedge clk) begin : mon
      logic [3:0] p;
      exp_t       e;
      int         s;
      if (mon_en) begin
         if (rq_p) begin
            chk("valid_cnt", valid_cnt, 1);
            chk("data_cnt", data_cnt, rq_exp);
         end else begin
            chk("valid_cnt_low", valid_cnt, 0);
         end
         if (init_s) for (int i = 0; i < 4; i++) cnt_m[i] = 0;
         rq_p = req;
         if (req) rq_exp = cnt_m[idx];

         if (pend && sb.size() > 0) begin
            e = sb.pop_front();
            if (init_s) begin
               chk("discard_valid", valid_out, 0);
            end else begin
               chk("deliv_valid", valid_out, 1);
               chk("deliv_data", data_out, e.data);
               chk("deliv_src", src_out, e.src);
               cnt_m[e.src] = (cnt_m[e.src] + 1) % 32;
            end
         end else begin
            chk("no_valid", valid_out, 0);
         end

         p = {pop7, pop6, pop5, pop4};
         chk("pop_onehot", $onehot0(p), 1);
         chk("pop_on_empty", p & emp, 0);
         if (!ready_s || init_s) chk("pop_gated", p, 0);
         pend = 1'b0;
         s = (p == 4'b0010) ? 1 : (p == 4'b0100) ? 2 : (p == 4'b1000) ? 3 : 0;
         if (p != 0) begin
            e.src = 2'(s);
            case (s)
               0: e.data = (q0.size() > 0) ? q0[0] : 10'h3FF;
               1: e.data = (q1.size() > 0) ? q1[0] : 10'h3FF;
               2: e.data = (q2.size() > 0) ? q2[0] : 10'h3FF;
               default: e.data = (q3.size() > 0) ? q3[0] : 10'h3FF;
            endcase
            sb.push_back(e);
            pend = 1'b1;
         end
      end
   end

   task automatic wait_idle(input int bound, input string nm);
      bit ok = 1'b0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         if (idle === 1'b1 && emp == 4'hF) ok = 1'b1;
      end
      chk(nm, ok, 1);
   endtask

   task automatic pulse_init();
      @(posedge clk); #1 init = 1'b1;
      @(posedge clk); #1 init = 1'b0;
      wait_idle(50, "idle_after_init");
   endtask

   typedef struct { logic ready; logic [3:0] pop; logic idle; } vec_t;
   vec_t vt[18];

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int   pc[$];
      int   dv;
      int   n6;
      int   n7;
      bit   hit;

      // Four-way rotation, then ready low for five cycles mid-stream.
      vt[0]  = '{1'b1, 4'b0000, 1'b1};
      vt[1]  = '{1'b1, 4'b0000, 1'b1};
      vt[2]  = '{1'b1, 4'b0000, 1'b0};
      vt[3]  = '{1'b1, 4'b0001, 1'b0};
      vt[4]  = '{1'b1, 4'b0010, 1'b0};
      vt[5]  = '{1'b1, 4'b0100, 1'b0};
      vt[6]  = '{1'b1, 4'b1000, 1'b0};
      vt[7]  = '{1'b1, 4'b0001, 1'b0};
      vt[8]  = '{1'b0, 4'b0010, 1'b0};
      vt[9]  = '{1'b0, 4'b0000, 1'b0};
      vt[10] = '{1'b0, 4'b0000, 1'b0};
      vt[11] = '{1'b0, 4'b0000, 1'b0};
      vt[12] = '{1'b0, 4'b0000, 1'b0};
      vt[13] = '{1'b1, 4'b0000, 1'b0};
      vt[14] = '{1'b1, 4'b0100, 1'b0};
      vt[15] = '{1'b1, 4'b1000, 1'b0};
      vt[16] = '{1'b1, 4'b0001, 1'b0};
      vt[17] = '{1'b1, 4'b0010, 1'b0};

      // Reset asserted before any clock edge must clear outputs immediately.
      #1 reset = 1'b0;
      #1;
      chk("rst_pops", {pop7, pop6, pop5, pop4}, 0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_src_out", src_out, 0);
      chk("rst_data_cnt", data_cnt, 0);
      chk("rst_valid_cnt", valid_cnt, 0);
      chk("rst_idle", idle, 0);

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 mon_en = 1'b1;
      @(negedge clk);
      chk("init_idle_low", idle, 0);
      @(posedge clk); #1 init = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("idle_after_init0", idle, 1);

      push_words(0, 10); push_words(1, 10); push_words(2, 10); push_words(3, 10);
      for (int k = 0; k < 18; k++) begin
         ready_in = vt[k].ready;
         @(negedge clk);
         chk($sformatf("vec%0d_pop", k), {pop7, pop6, pop5, pop4}, vt[k].pop);
         chk($sformatf("vec%0d_idle", k), idle, vt[k].idle);
         @(posedge clk); #1;
      end
      ready_in = 1'b1;
      wait_idle(300, "drain_all");

      // FIFO5 alone with three words.
      pulse_init();
      @(posedge clk); #1 push_words(1, 3);
      dv = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (pop5) pc.push_back(cyc);
         if (valid_out && src_out == 2'd1) dv++;
      end
      chk("pop5_count", pc.size(), 3);
      chk("deliv5_count", dv, 3);
      if (pc.size() >= 3) begin
         chk("pop5_gap1", pc[1] - pc[0], 2);
         chk("pop5_gap2", pc[2] - pc[1], 2);
      end
      wait_idle(50, "idle_after_f5");

      // 33 words from FIFO4 wrap its counter to 1.
      pulse_init();
      @(posedge clk); #1 push_words(0, 33);
      wait_idle(200, "drain_f4");
      @(posedge clk); #1 req = 1'b1; idx = 2'd0;
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("cnt4_wrap", data_cnt, 1);
      chk("cnt4_wrap_valid", valid_cnt, 1);

      // Read FIFO6 counter in the same cycle as its eighth delivery.
      pulse_init();
      @(posedge clk); #1 push_words(2, 8);
      n6 = 0; hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (pop6) n6++;
         if (n6 == 8) hit = 1'b1;
      end
      chk("pop6_eighth", hit, 1);
      @(posedge clk); #1 req = 1'b1; idx = 2'd2;
      @(negedge clk);
      chk("deliv6_8_valid", valid_out, 1);
      chk("deliv6_8_src", src_out, 2);
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("cnt6_pre_inc", data_cnt, 7);
      wait_idle(50, "idle_after_f6");
      @(posedge clk); #1 req = 1'b1; idx = 2'd2;
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("cnt6_post_inc", data_cnt, 8);

      // init lands while a pop is in flight.
      pulse_init();
      @(posedge clk); #1 push_words(0, 1);
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         @(negedge clk);
         if (pop4) begin
            hit = 1'b1;
            init = 1'b1;
         end
      end
      chk("pop4_seen", hit, 1);
      @(negedge clk);
      chk("inflight_dropped", valid_out, 0);
      chk("idle_in_init", idle, 0);
      @(posedge clk); #1 init = 1'b0;
      wait_idle(50, "idle_after_drop");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 req = 1'b1; idx = 2'(i);
         @(posedge clk); #1 req = 1'b0;
         @(negedge clk);
         chk($sformatf("cnt%0d_zero", i + 4), data_cnt, 0);
      end

      // Asynchronous reset in the middle of a FIFO7 stream.
      pulse_init();
      @(posedge clk); #1 push_words(3, 6);
      n7 = 0;
      for (int i = 0; i < 50 && n7 < 2; i++) begin
         @(negedge clk);
         if (valid_out && src_out == 2'd3) n7++;
      end
      chk("deliv7_two", n7, 2);
      @(posedge clk); #1 req = 1'b1; idx = 2'd3;
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("cnt7_pre_reset", data_cnt, 2);
      mon_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("arst_pops", {pop7, pop6, pop5, pop4}, 0);
      chk("arst_valid_out", valid_out, 0);
      chk("arst_data_out", data_out, 0);
      chk("arst_src_out", src_out, 0);
      chk("arst_data_cnt", data_cnt, 0);
      chk("arst_valid_cnt", valid_cnt, 0);
      chk("arst_idle", idle, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
